// File: rtl/noc_flit_injector.sv
// noc_flit_injector
//   Source-side network interface for the mesh NoC. Turns a local send
//   request (destination YX address plus N payload words) into a
//   header / body / tail flit stream for the router's local input port.
//
//   Flit format: [FLIT_W-1:FLIT_W-2] = type, [DATA_W-1:0] = data.
//     01 header, 00 body, 10 tail, 11 single-flit packet (len == 0).
//   Header data: [7:0] dest, [15:8] source address, [15+LEN_W:16] len,
//   all higher bits zero.
//
//   Handshakes: on all three interfaces a transfer happens in a cycle where
//   valid and ready are both high at the rising clock edge. Valid is never
//   made dependent on ready by the sender. The flit output is a single
//   register that may be reloaded only when it is empty or being drained
//   in the same cycle (out_free).
//
//   Optional build macro: NOC_INJ_SELF_DROP_EN
//     When defined, requests addressed to this node are handshaken but
//     produce no flits; their payload words are sunk at full rate, and the
//     extra output self_drop_o pulses in the request-accept cycle.
//     When undefined, self-addressed packets are emitted normally.
//
//   DATA_W must be at least 24 so the header fields fit; LEN_W is at most 8.

module noc_flit_injector #(
    parameter  int DATA_W = 32,
    parameter  int LEN_W  = 8,
    localparam int FLIT_W = DATA_W + 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [7:0]        local_addr_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [7:0]        req_dest_i,
    input  logic [LEN_W-1:0]  req_len_i,
    input  logic              pay_valid_i,
    output logic              pay_ready_o,
    input  logic [DATA_W-1:0] pay_data_i,
    output logic              flit_valid_o,
    input  logic              flit_ready_i,
    output logic [FLIT_W-1:0] flit_o,
    output logic              busy_o
`ifdef NOC_INJ_SELF_DROP_EN
    ,
    output logic              self_drop_o
`endif
);

    // Flit type encodings
    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    // IDLE waits for a request; BODY streams the payload words of a packet.
    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   cnt;        // payload words still to be accepted
    logic               out_free;   // output register may take a new flit
    logic               req_fire;
    logic               pay_fire;
    logic               last_word;  // the word being accepted ends the packet
    logic [DATA_W-1:0]  hdr_data;
    logic               self_hit;   // request targets this node and is dropped
    logic               drop_q;     // current packet is being sunk, not sent

    // Output register can be reloaded when empty or being drained now
    assign out_free  = !flit_valid_o || flit_ready_i;

    // Request side is open only between packets
    assign req_ready_o = (state == IDLE) && out_free;

    // Payload side is open only mid-packet; a dropped packet does not need
    // the output register, so it sinks words regardless of backpressure.
    assign pay_ready_o = (state == BODY) && (out_free || drop_q);

    assign req_fire  = req_valid_i && req_ready_o;
    assign pay_fire  = pay_valid_i && pay_ready_o;
    assign last_word = (cnt == LEN_W'(1));

    // A packet is in progress while mid-body or while a flit is still queued
    assign busy_o = (state != IDLE) || flit_valid_o;

`ifdef NOC_INJ_SELF_DROP_EN
    assign self_hit    = (req_dest_i == local_addr_i);
    assign self_drop_o = req_fire && self_hit;
`else
    assign self_hit = 1'b0;
    assign drop_q   = 1'b0;
`endif

    // Header payload assembled from the live request fields; only used on
    // the accept cycle, so no separate request register is needed.
    always_comb begin
        hdr_data              = '0;
        hdr_data[7:0]         = req_dest_i;
        hdr_data[15:8]        = local_addr_i;
        hdr_data[16 +: LEN_W] = req_len_i;
    end

    // Packet FSM with the registered flit output
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            cnt          <= '0;
            flit_valid_o <= 1'b0;
            flit_o       <= '0;
        end else begin
            // A drained register empties unless something is loaded below
            if (out_free) begin
                flit_valid_o <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (req_fire) begin
                        cnt <= req_len_i;
                        if (!self_hit) begin
                            flit_valid_o <= 1'b1;
                            flit_o       <= {(req_len_i == '0) ? T_SINGLE : T_HEAD,
                                             hdr_data};
                        end
                        if (req_len_i != '0) begin
                            state <= BODY;
                        end
                    end
                end

                BODY: begin
                    if (pay_fire) begin
                        cnt <= cnt - LEN_W'(1);
                        if (!drop_q) begin
                            flit_valid_o <= 1'b1;
                            flit_o       <= {last_word ? T_TAIL : T_BODY, pay_data_i};
                        end
                        if (last_word) begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef NOC_INJ_SELF_DROP_EN
    // Remember whether the packet in BODY is being sunk locally
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_q <= 1'b0;
        end else if (req_fire) begin
            drop_q <= self_hit;
        end
    end
`endif

endmodule

// File: tb/tb_noc_flit_injector.sv
// tb_noc_flit_injector
//   Directed bench for noc_flit_injector (default build). A packet-level
//   reference model tracks what the output register must hold and what the
//   ready outputs must be, and is compared on every falling edge. Router
//   accepted flits are recorded and also checked against literal streams.

module tb_noc_flit_injector;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;
    localparam int FLIT_W = DATA_W + 2;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst_ni;
    logic [7:0]        local_addr_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [7:0]        req_dest_i;
    logic [LEN_W-1:0]  req_len_i;
    logic              pay_valid_i;
    logic              pay_ready_o;
    logic [DATA_W-1:0] pay_data_i;
    logic              flit_valid_o;
    logic              flit_ready_i;
    logic [FLIT_W-1:0] flit_o;
    logic              busy_o;

    always #5 clk = ~clk;

    noc_flit_injector #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .local_addr_i (local_addr_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_dest_i   (req_dest_i),
        .req_len_i    (req_len_i),
        .pay_valid_i  (pay_valid_i),
        .pay_ready_o  (pay_ready_o),
        .pay_data_i   (pay_data_i),
        .flit_valid_o (flit_valid_o),
        .flit_ready_i (flit_ready_i),
        .flit_o       (flit_o),
        .busy_o       (busy_o)
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [FLIT_W-1:0] got_q[$];   // flits the router accepted
    int                got_t[$];   // cycle each was accepted
    logic [FLIT_W-1:0] exp_q[$];   // literal expected stream

    // Reference model: output register contents and payload words left
    bit                m_valid;
    logic [FLIT_W-1:0] m_flit;
    int                m_rem;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin : compare
        bit                free;
        bit                rr;
        bit                pr;
        bit                load;
        logic [DATA_W-1:0] d;
        logic [1:0]        t;
        if (!rst_ni) begin
            chk("rst_flit_valid", flit_valid_o, 0);
            chk("rst_flit",       flit_o,       0);
            chk("rst_busy",       busy_o,       0);
            chk("rst_req_ready",  req_ready_o,  1);
            chk("rst_pay_ready",  pay_ready_o,  0);
            m_valid = 0;
            m_flit  = '0;
            m_rem   = 0;
        end else begin
            free = !m_valid || flit_ready_i;
            rr   = (m_rem == 0) && free;
            pr   = (m_rem != 0) && free;
            chk("m_flit_valid", flit_valid_o, m_valid);
            if (m_valid) chk("m_flit", flit_o, m_flit);
            chk("m_req_ready", req_ready_o, rr);
            chk("m_pay_ready", pay_ready_o, pr);
            chk("m_busy",      busy_o,      (m_rem != 0) || m_valid);

            if (flit_valid_o && flit_ready_i) begin
                got_q.push_back(flit_o);
                got_t.push_back(cyc);
            end

            load = 0;
            if (req_valid_i && rr) begin
                d = (32'(req_len_i) << 16) + (32'(local_addr_i) << 8) + 32'(req_dest_i);
                t = (req_len_i == 0) ? 2'b11 : 2'b01;
                m_flit = {t, d};
                m_rem  = int'(req_len_i);
                load   = 1;
            end else if (pay_valid_i && pr) begin
                m_rem  = m_rem - 1;
                t      = (m_rem == 0) ? 2'b10 : 2'b00;
                m_flit = {t, pay_data_i};
                load   = 1;
            end
            if (free) m_valid = load;
        end
    end

    // ---------------- driver tasks ----------------
    // Called right after a rising edge; return right after the accepting edge.
    task automatic send_req(input logic [7:0] dest, input int len);
        bit done;
        done        = 0;
        req_valid_i = 1;
        req_dest_i  = dest;
        req_len_i   = LEN_W'(len);
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (req_ready_o) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) chk("req_timeout", 0, 1);
        req_valid_i = 0;
        req_dest_i  = 8'($urandom_range(0, 255));
        req_len_i   = LEN_W'($urandom_range(0, 255));
    endtask

    task automatic send_pay(input logic [DATA_W-1:0] data);
        bit done;
        done        = 0;
        pay_valid_i = 1;
        pay_data_i  = data;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (pay_ready_o) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) chk("pay_timeout", 0, 1);
        pay_valid_i = 0;
        pay_data_i  = DATA_W'($urandom);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (!busy_o) done = 1;
        end
        chk("drain", done, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string name, input bit consec);
        chk({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                chk({name, "_flit"}, got_q[i], exp_q[i]);
                if (consec) chk({name, "_gap"}, got_t[i] - got_t[0], i);
            end
        end
        got_q.delete();
        got_t.delete();
        exp_q.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_ni       = 0;
        local_addr_i = 8'h12;
        req_valid_i  = 0;
        req_dest_i   = '0;
        req_len_i    = '0;
        pay_valid_i  = 0;
        pay_data_i   = '0;
        flit_ready_i = 1;
        #1;
        chk("reset_valid",     flit_valid_o, 0);
        chk("reset_req_ready", req_ready_o,  1);
        repeat (3) @(posedge clk);
        #1;
        rst_ni = 1;

        // Payload offered while idle must be ignored
        pay_valid_i = 1;
        pay_data_i  = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_pay_ready", pay_ready_o, 0);
        pay_valid_i = 0;

        // Single-flit packet
        send_req(8'h34, 0);
        chk("single_valid",     flit_valid_o, 1);
        chk("single_flit",      flit_o,       34'h3_0000_1234);
        chk("single_req_ready", req_ready_o,  1);
        drain();
        exp_q.push_back(34'h3_0000_1234);
        check_stream("single", 1);

        // Three-flit payload at full rate
        send_req(8'h21, 3);
        send_pay(32'h0000_00A1);
        send_pay(32'h0000_00A2);
        send_pay(32'h0000_00A3);
        drain();
        exp_q.push_back(34'h1_0003_1221);
        exp_q.push_back(34'h0_0000_00A1);
        exp_q.push_back(34'h0_0000_00A2);
        exp_q.push_back(34'h2_0000_00A3);
        check_stream("three", 1);

        // Backpressure on the first body flit
        fork
            begin
                send_req(8'h21, 3);
                send_pay(32'h0000_00A1);
                send_pay(32'h0000_00A2);
                send_pay(32'h0000_00A3);
            end
            begin : stall
                bit seen;
                seen = 0;
                for (int i = 0; i < 40 && !seen; i++) begin
                    @(posedge clk);
                    #1;
                    if (flit_valid_o && flit_o[FLIT_W-1:FLIT_W-2] == 2'b00) seen = 1;
                end
                chk("stall_seen", seen, 1);
                if (seen) begin
                    flit_ready_i = 0;
                    #1;
                    for (int k = 0; k < 4; k++) begin
                        chk("stall_valid",     flit_valid_o, 1);
                        chk("stall_flit",      flit_o,       34'h0_0000_00A1);
                        chk("stall_pay_ready", pay_ready_o,  0);
                        @(posedge clk);
                        #1;
                    end
                    flit_ready_i = 1;
                end
            end
        join
        drain();
        exp_q.push_back(34'h1_0003_1221);
        exp_q.push_back(34'h0_0000_00A1);
        exp_q.push_back(34'h0_0000_00A2);
        exp_q.push_back(34'h2_0000_00A3);
        check_stream("backpressure", 0);

        // Back-to-back len=1 packets with no idle gap
        send_req(8'h55, 1);
        send_pay(32'h0000_00B1);
        send_req(8'h56, 1);
        send_pay(32'h0000_00B2);
        drain();
        exp_q.push_back(34'h1_0001_1255);
        exp_q.push_back(34'h2_0000_00B1);
        exp_q.push_back(34'h1_0001_1256);
        exp_q.push_back(34'h2_0000_00B2);
        check_stream("b2b", 1);

        // Reset in the middle of a len=4 packet with the header held
        flit_ready_i = 0;
        send_req(8'h43, 4);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_flit", flit_o, 34'h1_0004_1243);
        rst_ni = 0;
        #1;
        chk("midrst_valid",     flit_valid_o, 0);
        chk("midrst_flit",      flit_o,       0);
        chk("midrst_busy",      busy_o,       0);
        chk("midrst_req_ready", req_ready_o,  1);
        chk("midrst_pay_ready", pay_ready_o,  0);
        @(posedge clk);
        #1;
        rst_ni       = 1;
        flit_ready_i = 1;
        got_q.delete();
        got_t.delete();
        send_req(8'h66, 0);
        drain();
        exp_q.push_back(34'h3_0000_1266);
        check_stream("after_rst", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/noc_flit_injector.md
Name: noc_flit_injector

Overview:
- Source-side network interface for the mesh NoC. It converts a local core's send request (a destination YX address plus N payload words) into a header/body/tail flit stream.
- The stream drives the router's local input port, where the YX route computation consumes the header's destination byte.
- Valid/ready flow control on all three interfaces. Registered flit output.

Parameters:
- DATA_W, 32, payload word width; minimum 24, so the header fields fit.
- LEN_W, 8, width of the payload-length field; maximum 8.
- FLIT_W, DATA_W+2, flit width: 2-bit type field plus data; derived, not overridden.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- local_addr_i  in  8  this node's address: [7:4]=x, [3:0]=y; quasi-static
- req_valid_i  in  1  send request valid
- req_ready_o  out  1  send request accepted when req_valid_i & req_ready_o
- req_dest_i  in  8  destination address: [7:4]=x, [3:0]=y
- req_len_i  in  LEN_W  number of payload flits; 0 is legal
- pay_valid_i  in  1  payload word valid
- pay_ready_o  out  1  payload word accepted when pay_valid_i & pay_ready_o
- pay_data_i  in  DATA_W  payload word
- flit_valid_o  out  1  flit valid to router local port
- flit_ready_i  in  1  router accepts flit
- flit_o  out  FLIT_W  flit: [FLIT_W-1:FLIT_W-2]=type, [DATA_W-1:0]=data
- busy_o  out  1  packet in progress (state != IDLE, or flit_valid_o high)

Behaviour:
- Flit types:
  - 01 header
  - 00 body
  - 10 tail
  - 11 single-flit packet (header and tail in one flit)
- Header data layout:
  - [7:0] = dest
  - [15:8] = local_addr_i sampled at request accept
  - [15+LEN_W:16] = len
  - remaining bits 0
- Output register:
  - out_free = !flit_valid_o | flit_ready_i.
  - flit_o is loaded only when out_free.
  - flit_o and flit_valid_o hold stable while flit_valid_o & !flit_ready_i.
  - When out_free and nothing is loaded, flit_valid_o falls to 0.
- States: IDLE, BODY.
- IDLE:
  - req_ready_o = out_free; pay_ready_o = 0.
  - On request accept: latch dest and len into remaining count cnt, and load the header flit. Latency is 1 cycle: the header is valid in the cycle after the handshake.
  - If len==0: header type 11, stay in IDLE.
  - If len!=0: header type 01, go to BODY.
- BODY:
  - req_ready_o = 0; pay_ready_o = out_free.
  - Each payload accept loads the data into flit_o and decrements cnt.
  - If cnt==1 at accept: type 10, go to IDLE. Otherwise type 00.
- Throughput:
  - One flit per cycle when flit_ready_i is held high.
  - A new request may be accepted in the same cycle the previous tail is accepted by the router.
- Payload words beyond len are never consumed. Payload offered in IDLE is ignored (pay_ready_o=0).
- Request and payload inputs are captured only on handshake; changes while not ready have no effect.
- Reset (asynchronous, any time, including mid-packet):
  - state=IDLE, cnt=0, flit_valid_o=0, flit_o=0, busy_o=0.
  - Resulting outputs: req_ready_o=1, pay_ready_o=0.
  - Any partial packet is abandoned; no tail is emitted.

Optional Feature:
- Macro: NOC_INJ_SELF_DROP_EN.
- Defined:
  - A request with req_dest_i == local_addr_i is still handshaken normally, but no header is emitted.
  - If len!=0, the block enters BODY and sinks exactly len payload words, with pay_ready_o=1 regardless of out_free and no flits loaded.
  - It then returns to IDLE.
  - A 1-cycle pulse on added output port self_drop_o (out, 1) is asserted in the request-accept cycle. Reset value 0.
- Not defined:
  - Self-addressed packets are emitted like any other packet (the router delivers them to its local output).
  - self_drop_o does not exist.

Test Plan:
- Single-flit packet: reset, local_addr_i=8'h12, request dest=8'h34, len=0, flit_ready_i=1 -> one cycle later flit_o={2'b11, data with [7:0]=34, [15:8]=12, [23:16]=00}; req_ready_o stays 1.
- Three-flit payload: request dest=8'h21, len=3, then payload A1,A2,A3 with flit_ready_i=1 -> flit types 01,00,00,10 on consecutive cycles; data A1,A2,A3 on the body and tail flits.
- Backpressure: same as the three-flit case with flit_ready_i=0 for 4 cycles during the first body flit -> flit_o stable at {00,A1}, pay_ready_o=0, no payload lost; stream resumes in order.
- Back-to-back packets: two len=1 requests with flit_ready_i=1 -> second request accepted the cycle the first tail is accepted; stream 01,10,01,10 with no idle gap.
- Reset mid-packet: assert rst_ni=0 after the header of a len=4 packet -> flit_valid_o=0 immediately; after release, a len=0 request produces a type-11 header.
- With NOC_INJ_SELF_DROP_EN: request dest=local_addr_i, len=2 -> self_drop_o pulses once, 2 payload words consumed, flit_valid_o never asserts.
